// File: rtl/fpu_mul_pkg.sv
// Types and constants shared by the FPU_MUL mantissa multiplier stages.
// They cover the Booth partial products, the product width and the reduction FSM.
package fpu_mul_pkg;

  localparam int N_MANT = 24;
  localparam int NUM_PP = 13;
  localparam int PROD_W = 2 * N_MANT;

  // One radix-4 Booth partial product. Bit N_MANT+1 is the sign bit.
  typedef logic [N_MANT+1:0] pp_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } acc_state_e;

  // Number of ACCUM cycles needed to consume num_pp terms at pps terms per cycle.
  function automatic int accum_cycles(input int num_pp, input int pps);
    return (num_pp + pps - 1) / pps;
  endfunction

endpackage

// File: rtl/booth_pp_accumulator_if.sv
// Handshake bundle between signed_area_computation, the PP accumulator and the product consumer.
// Valid/ready rule: a transfer happens on a rising edge where valid and ready are both high.
// The source holds valid and its data stable until that edge, and ready may depend on valid.
interface booth_pp_accumulator_if;
  import fpu_mul_pkg::*;

  logic                i_valid;
  logic                o_ready;
  pp_t                 i_pp [NUM_PP];
  logic [PROD_W-1:0]   i_vector_m;
  logic                o_valid;
  logic                i_ready;
  logic [PROD_W-1:0]   o_product;

  modport master (
    output i_valid, i_pp, i_vector_m, i_ready,
    input  o_ready, o_valid, o_product
  );

  modport slave (
    input  i_valid, i_pp, i_vector_m, i_ready,
    output o_ready, o_valid, o_product
  );

endinterface

// File: rtl/booth_pp_accumulator_pp_shift_add.sv
// Adds the PPS_PER_CYCLE partial products that start at index idx to the accumulator.
// Each term is the magnitude bits [N:0] of the PP, shifted left by 2*index.
module pp_shift_add #(
  parameter int N             = 24,
  parameter int NUM_PP        = 13,
  parameter int WIDTH         = 2 * N,
  parameter int PPS_PER_CYCLE = 2,
  parameter int IDX_W         = 4
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [N+1:0]     pp [NUM_PP],
  input  logic [IDX_W-1:0] idx,
  output logic [WIDTH-1:0] sum
);

  // Scan every slot and keep those inside the window [idx, idx+PPS_PER_CYCLE).
  // Slots past NUM_PP never exist, so they add nothing. The sign bit is left out
  // on purpose: Vector_M already holds that column.
  always_comb begin
    sum = acc;
    for (int i = 0; i < NUM_PP; i++) begin
      if ((i >= int'(idx)) && (i < int'(idx) + PPS_PER_CYCLE)) begin
        sum = sum + (WIDTH'(pp[i][N:0]) << (2 * i));
      end
    end
  end

endmodule

// File: rtl/booth_pp_accumulator.sv
// Iterative Booth partial-product reduction. It captures one PP set and Vector_M,
// then adds PPS_PER_CYCLE shifted PPs per cycle into a WIDTH-bit product.
module booth_pp_accumulator #(
  parameter int N             = fpu_mul_pkg::N_MANT,
  parameter int NUM_PP        = fpu_mul_pkg::NUM_PP,
  parameter int WIDTH         = 2 * N,
  // Legal range is 1..NUM_PP.
  parameter int PPS_PER_CYCLE = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  booth_pp_accumulator_if.slave    bus,
  output logic                     o_busy,
  output fpu_mul_pkg::acc_state_e  o_state
);

  typedef fpu_mul_pkg::acc_state_e state_t;

  localparam int IDX_W = $clog2(NUM_PP + PPS_PER_CYCLE + 1);

  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   idx_nxt;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   acc_sum;
  logic [N+1:0]       pp_bank [NUM_PP];
  logic               ready;
  logic               accept;

  assign idx_nxt = idx + IDX_W'(PPS_PER_CYCLE);

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    case (state)
      fpu_mul_pkg::IDLE:  ready = 1'b1;
      fpu_mul_pkg::DONE:  ready = bus.i_ready;
      default:            ready = 1'b0;
    endcase
    accept = bus.i_valid & ready;

    case (state)
      fpu_mul_pkg::IDLE: begin
        if (accept) state_nxt = fpu_mul_pkg::ACCUM;
      end
      fpu_mul_pkg::ACCUM: begin
        if (int'(idx_nxt) >= NUM_PP) state_nxt = fpu_mul_pkg::DONE;
      end
      fpu_mul_pkg::DONE: begin
        // Pop and push in the same cycle skip IDLE, so back-to-back sets have no bubble.
        if (bus.i_ready) state_nxt = accept ? fpu_mul_pkg::ACCUM : fpu_mul_pkg::IDLE;
      end
      default: state_nxt = fpu_mul_pkg::IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= fpu_mul_pkg::IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  pp_shift_add #(
    .N             (N),
    .NUM_PP        (NUM_PP),
    .WIDTH         (WIDTH),
    .PPS_PER_CYCLE (PPS_PER_CYCLE),
    .IDX_W         (IDX_W)
  ) u_pp_shift_add (
    .acc (acc),
    .pp  (pp_bank),
    .idx (idx),
    .sum (acc_sum)
  );

  // Reset wipes the bank and the accumulator, so an interrupted op can never be emitted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      idx <= '0;
      acc <= '0;
      for (int i = 0; i < NUM_PP; i++) pp_bank[i] <= '0;
    end else if (accept) begin
      idx <= '0;
      acc <= bus.i_vector_m;
      for (int i = 0; i < NUM_PP; i++) pp_bank[i] <= bus.i_pp[i];
    end else if (state == fpu_mul_pkg::ACCUM) begin
      idx <= idx_nxt;
      acc <= acc_sum;
    end
  end

  assign bus.o_ready   = ready;
  assign bus.o_valid   = (state == fpu_mul_pkg::DONE);
  assign bus.o_product = acc;
  assign o_busy        = (state == fpu_mul_pkg::ACCUM);
  assign o_state       = state;

endmodule
